// File: rtl/mips_cpu_bus_lsu_ctrl.sv
// Load/store unit bus controller: turns core data requests into one word-aligned
// bus transfer with lane enables, store replication and load extraction/extension.
module mips_cpu_bus_lsu_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    input  logic        waitrequest,
    input  logic [31:0] readdata
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;

    state_t      state;
    logic        lat_write;
    logic        lat_signed;
    logic [1:0]  lat_size;
    logic [1:0]  lat_offset;

    logic        legal;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    assign req_ready = (state == IDLE);

    // Legality, lane enables and lane replication come straight from the incoming request.
    always_comb begin
        legal      = 1'b0;
        be_next    = 4'b0000;
        wdata_next = 32'h0;
        case (req_size)
            2'b00: begin
                legal      = 1'b1;
                be_next    = 4'b0001 << req_addr[1:0];
                wdata_next = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                legal      = ~req_addr[0];
                be_next    = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                legal      = (req_addr[1:0] == 2'b00);
                be_next    = 4'b1111;
                wdata_next = req_wdata;
            end
            default: begin
                legal      = 1'b0;
            end
        endcase
    end

    always_comb begin
        byte_sel = readdata[7:0];
        case (lat_offset)
            2'd0:    byte_sel = readdata[7:0];
            2'd1:    byte_sel = readdata[15:8];
            2'd2:    byte_sel = readdata[23:16];
            default: byte_sel = readdata[31:24];
        endcase
        half_sel = lat_offset[1] ? readdata[31:16] : readdata[15:0];
        case (lat_size)
            2'b00:   load_ext = {{24{lat_signed & byte_sel[7]}}, byte_sel};
            2'b01:   load_ext = {{16{lat_signed & half_sel[15]}}, half_sel};
            default: load_ext = readdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            read       <= 1'b0;
            write      <= 1'b0;
            address    <= 32'h0;
            byteenable <= 4'b0000;
            writedata  <= 32'h0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
            lat_write  <= 1'b0;
            lat_signed <= 1'b0;
            lat_size   <= 2'b00;
            lat_offset <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_write  <= req_write;
                        lat_signed <= req_signed;
                        lat_size   <= req_size;
                        lat_offset <= req_addr[1:0];
                        if (legal) begin
                            state      <= BUS;
                            read       <= ~req_write;
                            write      <= req_write;
                            address    <= {req_addr[31:2], 2'b00};
                            byteenable <= be_next;
                            writedata  <= wdata_next;
                        end else begin
                            // Illegal accesses never touch the bus.
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                        end
                    end
                end
                BUS: begin
                    if (!waitrequest) begin
                        state      <= RESP;
                        read       <= 1'b0;
                        write      <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= lat_write ? 32'h0 : load_ext;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'h0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mips_cpu_bus_lsu_ctrl.sv
// Self-checking bench for the LSU bus controller: directed corner cases plus
// randomized accesses compared against an arithmetic reference model.
module tb_mips_cpu_bus_lsu_ctrl;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic        waitrequest;
    logic [31:0] readdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mips_cpu_bus_lsu_ctrl dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .address(address), .read(read), .write(write),
        .byteenable(byteenable), .writedata(writedata),
        .waitrequest(waitrequest), .readdata(readdata)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: plain arithmetic on size and byte offset.
    function automatic logic modelLegal(input logic [1:0] sz, input logic [31:0] ad);
        int off = int'(ad % 4);
        if (sz == 2'd0) return 1'b1;
        if (sz == 2'd1) return (off % 2) == 0;
        if (sz == 2'd2) return off == 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] modelBe(input logic [1:0] sz, input logic [31:0] ad);
        int off = int'(ad % 4);
        if (sz == 2'd0) return 4'(1 << off);
        if (sz == 2'd1) return 4'(3 << off);
        return 4'hF;
    endfunction

    function automatic logic [31:0] modelWdata(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'd0) return (wd & 32'hFF) * 32'h01010101;
        if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [1:0] sz, input logic sg,
                                              input logic [31:0] ad, input logic [31:0] rd);
        logic [31:0] v = rd >> (8 * (ad % 4));
        logic [31:0] b = v & 32'hFF;
        logic [31:0] h = v & 32'hFFFF;
        if (sz == 2'd0) return (sg && b >= 128) ? b + 32'hFFFFFF00 : b;
        if (sz == 2'd1) return (sg && h >= 32768) ? h + 32'hFFFF0000 : h;
        return rd;
    endfunction

    task automatic waitReady(output bit ok);
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (req_ready === 1'b1) ok = 1;
        end
        if (!ok) checkOutput("ready_timeout", 32'd0, 32'd1);
    endtask

    // One full access: issue it, play the slave with the given wait states, check every cycle.
    task automatic applyStimulus(input logic wr, input logic [1:0] sz, input logic sg,
                                 input logic [31:0] ad, input logic [31:0] wd,
                                 input logic [31:0] rd, input int waits);
        bit ok;
        bit gotResp;
        int busCycles;
        logic legal;
        int expCycles;
        logic [31:0] expRdata;
        legal     = modelLegal(sz, ad);
        expCycles = legal ? 3 + waits : 2;
        expRdata  = (legal && !wr) ? modelLoad(sz, sg, ad, rd) : 32'h0;
        waitReady(ok);
        if (!ok) return;
        req_valid = 1'b1; req_write = wr; req_size = sz;
        req_signed = sg; req_addr = ad; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
        req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        busCycles = 0;
        gotResp = 0;
        for (int k = 0; k < 40 && !gotResp; k++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                gotResp = 1;
                checkOutput("latency", 32'(k + 2), 32'(expCycles));
                checkOutput("resp_err", resp_err, !legal);
                checkOutput("resp_rdata", resp_rdata, expRdata);
                checkOutput("strobe_in_resp", {read, write}, 32'd0);
                checkOutput("bus_cycles", 32'(busCycles), legal ? 32'(waits + 1) : 32'd0);
            end else begin
                checkOutput("ready_busy", req_ready, 32'd0);
                checkOutput("read", read, legal && !wr);
                checkOutput("write", write, legal && wr);
                checkOutput("rdata_idle", resp_rdata, 32'd0);
                checkOutput("err_idle", resp_err, 32'd0);
                if (read || write) begin
                    busCycles++;
                    checkOutput("address", address, {ad[31:2], 2'b00});
                    checkOutput("byteenable", byteenable, modelBe(sz, ad));
                    if (wr) checkOutput("writedata", writedata, modelWdata(sz, wd));
                end
                waitrequest = (busCycles <= waits);
                readdata    = waitrequest ? $urandom : rd;
            end
        end
        waitrequest = 1'b0;
        if (!gotResp) checkOutput("resp_timeout", 32'd0, 32'd1);
        @(negedge clk);
        checkOutput("resp_one_cycle", resp_valid, 32'd0);
        checkOutput("ready_after", req_ready, 32'd1);
        checkOutput("rdata_after", resp_rdata, 32'd0);
        checkOutput("err_after", resp_err, 32'd0);
    endtask

    task automatic resetMidBus();
        bit ok;
        waitReady(ok);
        if (!ok) return;
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2;
        req_signed = 1'b0; req_addr = 32'h40; req_wdata = 32'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        waitrequest = 1'b1;
        @(negedge clk);
        checkOutput("rst_pre_read", read, 32'd1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_read", read, 32'd0);
        checkOutput("rst_write", write, 32'd0);
        checkOutput("rst_resp", resp_valid, 32'd0);
        checkOutput("rst_ready", req_ready, 32'd1);
        checkOutput("rst_address", address, 32'd0);
        checkOutput("rst_be", byteenable, 32'd0);
        waitrequest = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("rst_no_resp", resp_valid, 32'd0);
        end
    endtask

    initial begin
        logic [1:0]  sz;
        logic [31:0] ad;
        reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        waitrequest = 1'b0; readdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_ready", req_ready, 32'd1);
        checkOutput("reset_strobes", {read, write}, 32'd0);
        checkOutput("reset_resp", {resp_valid, resp_err}, 32'd0);
        checkOutput("reset_address", address, 32'd0);
        checkOutput("reset_be", byteenable, 32'd0);
        checkOutput("reset_wdata", writedata, 32'd0);
        checkOutput("reset_rdata", resp_rdata, 32'd0);
        reset_n = 1'b1;

        applyStimulus(1'b0, 2'd0, 1'b1, 32'h1003, 32'h0, 32'h80000000, 0);
        applyStimulus(1'b0, 2'd1, 1'b0, 32'h2002, 32'h0, 32'h80010000, 2);
        applyStimulus(1'b1, 2'd0, 1'b0, 32'h10, 32'h000000A5, 32'h12345678, 0);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h06, 32'h0, 32'hCAFEF00D, 0);
        applyStimulus(1'b1, 2'd3, 1'b0, 32'h100, 32'h11223344, 32'h0, 0);
        applyStimulus(1'b1, 2'd1, 1'b0, 32'h202, 32'h0000BEEF, 32'h0, 1);
        applyStimulus(1'b0, 2'd1, 1'b1, 32'h300, 32'h0, 32'h1234F00F, 0);
        resetMidBus();
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h44, 32'h0, 32'hDEADBEEF, 1);

        for (int n = 0; n < 60; n++) begin
            sz = 2'($urandom_range(0, 3));
            ad = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) ad[0] = 1'b0;
                if (sz == 2'd2) ad[1:0] = 2'b00;
            end
            applyStimulus(1'($urandom), sz, 1'($urandom), ad, $urandom, $urandom,
                          int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
